vga_vram_arbiter: RTL

Shares the single video RAM Wishbone port between two masters: the CPU-side memory interface master and the video frame fetch master.
- Video fetch has priority, with a starvation guard that guarantees the CPU one slot after a run of video grants.
- A watchdog ends any grant whose RAM acknowledge never arrives, so neither master can hang.
- Sits between the VGA core's two master ports and the external video SRAM controller.

---
 rtl/vga_arb_pkg.sv | 16 +
 rtl/vga_arb_watchdog.sv | 27 ++
 rtl/vga_vram_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/vga_arb_pkg.sv
// Shared types and widths for the video RAM arbiter.
// Holds the arbiter state encoding and the fixed video-fetch byte select.
package vga_arb_pkg;

    localparam int ADR_W = 17;
    localparam int DAT_W = 16;

    localparam logic [1:0] SEL_VID = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_VID = 2'd1,
        GNT_CPU = 2'd2
    } arb_state_e;

endpackage

// File: rtl/vga_arb_watchdog.sv
// Grant watchdog: counts grant cycles without a RAM acknowledge.
// Flags expiry for exactly the cycle in which the last allowed cycle passes unacknowledged.
module vga_arb_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic active,
    input  logic ack,
    input  logic clear,
    output logic expire
);

    logic [7:0] wd_cnt;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || clear) begin
            wd_cnt <= 8'd0;
        end else if (active && !ack) begin
            wd_cnt <= wd_cnt + 8'd1;
        end
    end

    // An ack in the final cycle wins over expiry.
    assign expire = active && !ack && (wd_cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/vga_vram_arbiter.sv
// Two-master arbiter for the video RAM Wishbone port: video fetch has priority,
// the CPU is guaranteed a slot after a run of video grants, and a watchdog ends stuck grants.
module vga_vram_arbiter
    import vga_arb_pkg::*;
#(
    parameter int MAX_VID_RUN = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [ADR_W-1:0] cpu_adr_i,
    input  logic [DAT_W-1:0] cpu_dat_i,
    input  logic [1:0]       cpu_sel_i,
    input  logic             cpu_we_i,
    input  logic             cpu_stb_i,
    output logic [DAT_W-1:0] cpu_dat_o,
    output logic             cpu_ack_o,
    input  logic [ADR_W-1:0] vid_adr_i,
    input  logic             vid_stb_i,
    output logic [DAT_W-1:0] vid_dat_o,
    output logic             vid_ack_o,
    output logic [ADR_W-1:0] ram_adr_o,
    output logic [DAT_W-1:0] ram_dat_o,
    output logic [1:0]       ram_sel_o,
    output logic             ram_we_o,
    output logic             ram_stb_o,
    output logic             ram_cyc_o,
    input  logic [DAT_W-1:0] ram_dat_i,
    input  logic             ram_ack_i,
    output logic             gnt_vid_o,
    output logic             gnt_cpu_o,
    output logic             timeout_o
);

    localparam logic [3:0] RUN_MAX = 4'(MAX_VID_RUN);

    // Handshake: a master request (stb) is held until its ack or until it
    // withdraws; ack is a single-cycle pulse valid together with its data, and a
    // withdrawn strobe ends the grant with no ack.
    arb_state_e state_q, state_d;
    logic [3:0] run_cnt_q, run_cnt_d;
    logic       wd_active;
    logic       wd_expire;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            run_cnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        ram_adr_o = '0;
        ram_dat_o = '0;
        ram_sel_o = 2'b00;
        ram_we_o  = 1'b0;
        ram_stb_o = 1'b0;
        cpu_ack_o = 1'b0;
        vid_ack_o = 1'b0;
        cpu_dat_o = ram_dat_i;
        case (state_q)
            IDLE: begin
                if (vid_stb_i && !(cpu_stb_i && run_cnt_q == RUN_MAX)) begin
                    state_d = GNT_VID;
                    if (!cpu_stb_i) begin
                        run_cnt_d = 4'd0;
                    end else if (run_cnt_q < RUN_MAX) begin
                        run_cnt_d = run_cnt_q + 4'd1;
                    end
                end else if (cpu_stb_i) begin
                    state_d   = GNT_CPU;
                    run_cnt_d = 4'd0;
                end
            end
            GNT_VID: begin
                ram_adr_o = vid_adr_i;
                ram_sel_o = SEL_VID;
                ram_stb_o = vid_stb_i;
                vid_ack_o = ram_ack_i && vid_stb_i;
                if (!vid_stb_i || ram_ack_i || wd_expire) begin
                    state_d = IDLE;
                end
            end
            GNT_CPU: begin
                ram_adr_o = cpu_adr_i;
                ram_dat_o = cpu_dat_i;
                ram_sel_o = cpu_sel_i;
                ram_we_o  = cpu_we_i;
                ram_stb_o = cpu_stb_i;
                // A stuck CPU access is released with a dummy zero read.
                cpu_ack_o = (ram_ack_i && cpu_stb_i) || wd_expire;
                if (wd_expire) begin
                    cpu_dat_o = '0;
                end
                if (!cpu_stb_i || ram_ack_i || wd_expire) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign wd_active = (state_q == GNT_VID && vid_stb_i) ||
                       (state_q == GNT_CPU && cpu_stb_i);

    vga_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .active   (wd_active),
        .ack      (ram_ack_i),
        .clear    (state_q == IDLE),
        .expire   (wd_expire)
    );

    assign vid_dat_o = ram_dat_i;
    assign ram_cyc_o = ram_stb_o;
    assign gnt_vid_o = (state_q == GNT_VID);
    assign gnt_cpu_o = (state_q == GNT_CPU);
    assign timeout_o = wd_expire;

endmodule
